mem_port_arbiter: RTL and testbench

//  Shares one downstream memory port between two upstream requesters.

---
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-to-one memory port arbiter: the I-cache (port 0) and D-cache (port 1)
// share one downstream memory port, one transaction (request + reply) at a
// time. Round-robin between ports, or port 0 always wins when FIXED_PRIO=1.
//
// state | meaning
// IDLE  | no transaction; pick a port, register the grant
// RREQ  | granted port's read request forwarded to memory
// RRESP | waiting for the memory read reply, routed to the granted port
// WREQ  | granted port's write request forwarded to memory
// WRESP | waiting for the memory write reply, routed to the granted port
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128,
   parameter int FIXED_PRIO = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   // requester 0 (I-cache side)
   input  logic                      up0_r_request_valid,
   output logic                      up0_r_request_ready,
   input  logic [ADDR_WIDTH-1:0]     up0_r_request_addr,
   output logic                      up0_r_reply_valid,
   input  logic                      up0_r_reply_ready,
   output logic [DATA_WIDTH-1:0]     up0_r_reply_data,
   output logic [1:0]                up0_r_reply_resp,
   input  logic                      up0_w_request_valid,
   output logic                      up0_w_request_ready,
   input  logic [ADDR_WIDTH-1:0]     up0_w_request_addr,
   input  logic [DATA_WIDTH-1:0]     up0_w_request_data,
   input  logic [DATA_WIDTH/8-1:0]   up0_w_request_mask,
   output logic                      up0_w_reply_valid,
   input  logic                      up0_w_reply_ready,
   output logic [1:0]                up0_w_reply_resp,
   // requester 1 (D-cache side)
   input  logic                      up1_r_request_valid,
   output logic                      up1_r_request_ready,
   input  logic [ADDR_WIDTH-1:0]     up1_r_request_addr,
   output logic                      up1_r_reply_valid,
   input  logic                      up1_r_reply_ready,
   output logic [DATA_WIDTH-1:0]     up1_r_reply_data,
   output logic [1:0]                up1_r_reply_resp,
   input  logic                      up1_w_request_valid,
   output logic                      up1_w_request_ready,
   input  logic [ADDR_WIDTH-1:0]     up1_w_request_addr,
   input  logic [DATA_WIDTH-1:0]     up1_w_request_data,
   input  logic [DATA_WIDTH/8-1:0]   up1_w_request_mask,
   output logic                      up1_w_reply_valid,
   input  logic                      up1_w_reply_ready,
   output logic [1:0]                up1_w_reply_resp,
   // shared downstream memory port
   output logic                      mem_r_request_valid,
   input  logic                      mem_r_request_ready,
   output logic [ADDR_WIDTH-1:0]     mem_r_request_addr,
   input  logic                      mem_r_reply_valid,
   output logic                      mem_r_reply_ready,
   input  logic [DATA_WIDTH-1:0]     mem_r_reply_data,
   input  logic [1:0]                mem_r_reply_resp,
   output logic                      mem_w_request_valid,
   input  logic                      mem_w_request_ready,
   output logic [ADDR_WIDTH-1:0]     mem_w_request_addr,
   output logic [DATA_WIDTH-1:0]     mem_w_request_data,
   output logic [DATA_WIDTH/8-1:0]   mem_w_request_mask,
   input  logic                      mem_w_reply_valid,
   output logic                      mem_w_reply_ready,
   input  logic [1:0]                mem_w_reply_resp
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RREQ  = 3'd1,
      RRESP = 3'd2,
      WREQ  = 3'd3,
      WRESP = 3'd4
   } state_t;

   state_t state_q, state_d;
   logic   grant_q, grant_d;
   logic   last_q, last_d;

   logic                    req0, req1, pick, pick_write;
   logic                    sel_r_valid, sel_r_reply_ready;
   logic                    sel_w_valid, sel_w_reply_ready;
   logic [ADDR_WIDTH-1:0]   sel_r_addr, sel_w_addr;
   logic [DATA_WIDTH-1:0]   sel_w_data;
   logic [DATA_WIDTH/8-1:0] sel_w_mask;

   assign req0 = up0_r_request_valid | up0_w_request_valid;
   assign req1 = up1_r_request_valid | up1_w_request_valid;

   // tie goes to port 0 in fixed mode, else to the port not served last
   assign pick       = (req0 & req1) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_q) : req1;
   // a pending write (writeback) goes ahead of a read (refill) from the same port
   assign pick_write = pick ? up1_w_request_valid : up0_w_request_valid;

   assign sel_r_valid       = grant_q ? up1_r_request_valid : up0_r_request_valid;
   assign sel_r_addr        = grant_q ? up1_r_request_addr  : up0_r_request_addr;
   assign sel_r_reply_ready = grant_q ? up1_r_reply_ready   : up0_r_reply_ready;
   assign sel_w_valid       = grant_q ? up1_w_request_valid : up0_w_request_valid;
   assign sel_w_addr        = grant_q ? up1_w_request_addr  : up0_w_request_addr;
   assign sel_w_data        = grant_q ? up1_w_request_data  : up0_w_request_data;
   assign sel_w_mask        = grant_q ? up1_w_request_mask  : up0_w_request_mask;
   assign sel_w_reply_ready = grant_q ? up1_w_reply_ready   : up0_w_reply_ready;

   // state, grant and last-served registers; last=1 so port 0 wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // next state and channel routing; everything off the active channel stays 0
   always_comb begin
      state_d             = state_q;
      grant_d             = grant_q;
      last_d              = last_q;
      up0_r_request_ready = 1'b0;
      up0_r_reply_valid   = 1'b0;
      up0_r_reply_data    = '0;
      up0_r_reply_resp    = '0;
      up0_w_request_ready = 1'b0;
      up0_w_reply_valid   = 1'b0;
      up0_w_reply_resp    = '0;
      up1_r_request_ready = 1'b0;
      up1_r_reply_valid   = 1'b0;
      up1_r_reply_data    = '0;
      up1_r_reply_resp    = '0;
      up1_w_request_ready = 1'b0;
      up1_w_reply_valid   = 1'b0;
      up1_w_reply_resp    = '0;
      mem_r_request_valid = 1'b0;
      mem_r_request_addr  = '0;
      mem_r_reply_ready   = 1'b0;
      mem_w_request_valid = 1'b0;
      mem_w_request_addr  = '0;
      mem_w_request_data  = '0;
      mem_w_request_mask  = '0;
      mem_w_reply_ready   = 1'b0;

      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               grant_d = pick;
               state_d = pick_write ? WREQ : RREQ;
            end
         end
         RREQ: begin
            mem_r_request_valid = sel_r_valid;
            mem_r_request_addr  = sel_r_valid ? sel_r_addr : '0;
            if (grant_q) up1_r_request_ready = mem_r_request_ready;
            else         up0_r_request_ready = mem_r_request_ready;
            if (sel_r_valid & mem_r_request_ready) state_d = RRESP;
         end
         RRESP: begin
            if (grant_q) begin
               up1_r_reply_valid = mem_r_reply_valid;
               up1_r_reply_data  = mem_r_reply_valid ? mem_r_reply_data : '0;
               up1_r_reply_resp  = mem_r_reply_valid ? mem_r_reply_resp : '0;
            end else begin
               up0_r_reply_valid = mem_r_reply_valid;
               up0_r_reply_data  = mem_r_reply_valid ? mem_r_reply_data : '0;
               up0_r_reply_resp  = mem_r_reply_valid ? mem_r_reply_resp : '0;
            end
            mem_r_reply_ready = sel_r_reply_ready;
            if (mem_r_reply_valid & sel_r_reply_ready) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
         end
         WREQ: begin
            mem_w_request_valid = sel_w_valid;
            mem_w_request_addr  = sel_w_valid ? sel_w_addr : '0;
            mem_w_request_data  = sel_w_valid ? sel_w_data : '0;
            mem_w_request_mask  = sel_w_valid ? sel_w_mask : '0;
            if (grant_q) up1_w_request_ready = mem_w_request_ready;
            else         up0_w_request_ready = mem_w_request_ready;
            if (sel_w_valid & mem_w_request_ready) state_d = WRESP;
         end
         WRESP: begin
            if (grant_q) begin
               up1_w_reply_valid = mem_w_reply_valid;
               up1_w_reply_resp  = mem_w_reply_valid ? mem_w_reply_resp : '0;
            end else begin
               up0_w_reply_valid = mem_w_reply_valid;
               up0_w_reply_resp  = mem_w_reply_valid ? mem_w_reply_resp : '0;
            end
            mem_w_reply_ready = sel_w_reply_ready;
            if (mem_w_reply_valid & sel_w_reply_ready) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance 0 is round-robin, instance 1
// is fixed priority; both share the upstream stimulus, each has its own
// memory-side inputs.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;

   logic [1:0]   u_rv, u_rrdy, u_wv, u_brdy;
   logic [31:0]  u_raddr [2];
   logic [31:0]  u_waddr [2];
   logic [127:0] u_wdata [2];
   logic [15:0]  u_wmask [2];

   logic [1:0]   m_rqrdy, m_rpv, m_wqrdy, m_bv;
   logic [127:0] m_rdata [2];
   logic [1:0]   m_rresp [2];
   logic [1:0]   m_bresp [2];

   logic         o_rqrdy [4];
   logic         o_rpv   [4];
   logic         o_wqrdy [4];
   logic         o_bv    [4];
   logic [127:0] o_rdata [4];
   logic [1:0]   o_rresp [4];
   logic [1:0]   o_bresp [4];

   logic         mo_rv    [2];
   logic         mo_rrdy  [2];
   logic         mo_wv    [2];
   logic         mo_brdy  [2];
   logic [31:0]  mo_raddr [2];
   logic [31:0]  mo_waddr [2];
   logic [127:0] mo_wdata [2];
   logic [15:0]  mo_wmask [2];
   logic         act      [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(128), .FIXED_PRIO(k)) u_dut (
         .clk                 (clk),
         .rst                 (rst),
         .up0_r_request_valid (u_rv[0]),
         .up0_r_request_ready (o_rqrdy[2*k]),
         .up0_r_request_addr  (u_raddr[0]),
         .up0_r_reply_valid   (o_rpv[2*k]),
         .up0_r_reply_ready   (u_rrdy[0]),
         .up0_r_reply_data    (o_rdata[2*k]),
         .up0_r_reply_resp    (o_rresp[2*k]),
         .up0_w_request_valid (u_wv[0]),
         .up0_w_request_ready (o_wqrdy[2*k]),
         .up0_w_request_addr  (u_waddr[0]),
         .up0_w_request_data  (u_wdata[0]),
         .up0_w_request_mask  (u_wmask[0]),
         .up0_w_reply_valid   (o_bv[2*k]),
         .up0_w_reply_ready   (u_brdy[0]),
         .up0_w_reply_resp    (o_bresp[2*k]),
         .up1_r_request_valid (u_rv[1]),
         .up1_r_request_ready (o_rqrdy[2*k+1]),
         .up1_r_request_addr  (u_raddr[1]),
         .up1_r_reply_valid   (o_rpv[2*k+1]),
         .up1_r_reply_ready   (u_rrdy[1]),
         .up1_r_reply_data    (o_rdata[2*k+1]),
         .up1_r_reply_resp    (o_rresp[2*k+1]),
         .up1_w_request_valid (u_wv[1]),
         .up1_w_request_ready (o_wqrdy[2*k+1]),
         .up1_w_request_addr  (u_waddr[1]),
         .up1_w_request_data  (u_wdata[1]),
         .up1_w_request_mask  (u_wmask[1]),
         .up1_w_reply_valid   (o_bv[2*k+1]),
         .up1_w_reply_ready   (u_brdy[1]),
         .up1_w_reply_resp    (o_bresp[2*k+1]),
         .mem_r_request_valid (mo_rv[k]),
         .mem_r_request_ready (m_rqrdy[k]),
         .mem_r_request_addr  (mo_raddr[k]),
         .mem_r_reply_valid   (m_rpv[k]),
         .mem_r_reply_ready   (mo_rrdy[k]),
         .mem_r_reply_data    (m_rdata[k]),
         .mem_r_reply_resp    (m_rresp[k]),
         .mem_w_request_valid (mo_wv[k]),
         .mem_w_request_ready (m_wqrdy[k]),
         .mem_w_request_addr  (mo_waddr[k]),
         .mem_w_request_data  (mo_wdata[k]),
         .mem_w_request_mask  (mo_wmask[k]),
         .mem_w_reply_valid   (m_bv[k]),
         .mem_w_reply_ready   (mo_brdy[k]),
         .mem_w_reply_resp    (m_bresp[k])
      );

      assign act[k] = o_rqrdy[2*k] | o_rqrdy[2*k+1] | o_rpv[2*k] | o_rpv[2*k+1] |
                      o_wqrdy[2*k] | o_wqrdy[2*k+1] | o_bv[2*k]  | o_bv[2*k+1]  |
                      mo_rv[k] | mo_rrdy[k] | mo_wv[k] | mo_brdy[k];
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // serve one read on instance k, expecting it to come from exp_port/exp_addr
   task automatic mem_read(input int k, input int exp_port, input logic [31:0] exp_addr);
      int n = 0;
      #1;
      while (!mo_rv[k] && n < 20) begin
         tick();
         n++;
      end
      chk("rd_grant_wait", 128'(mo_rv[k]), 128'(1));
      chk("rd_addr", 128'(mo_raddr[k]), 128'(exp_addr));
      m_rqrdy[k] = 1'b1;
      #1;
      chk("rd_up_ready", 128'({o_rqrdy[2*k+1], o_rqrdy[2*k]}),
          128'((exp_port == 1) ? 2'b10 : 2'b01));
      tick();
      m_rqrdy[k] = 1'b0;
      m_rpv[k]   = 1'b1;
      m_rdata[k] = {4{exp_addr}};
      m_rresp[k] = 2'b00;
      #1;
      chk("rd_reply_route", 128'({o_rpv[2*k+1], o_rpv[2*k]}),
          128'((exp_port == 1) ? 2'b10 : 2'b01));
      chk("rd_reply_data", o_rdata[2*k+exp_port], {4{exp_addr}});
      tick();
      m_rpv[k] = 1'b0;
   endtask

   logic [31:0] held_addr;

   initial begin
      rst = 1'b1;
      u_rv = '0; u_rrdy = '0; u_wv = '0; u_brdy = '0;
      m_rqrdy = '0; m_rpv = '0; m_wqrdy = '0; m_bv = '0;
      for (int i = 0; i < 2; i++) begin
         u_raddr[i] = '0; u_waddr[i] = '0; u_wdata[i] = '0; u_wmask[i] = '0;
         m_rdata[i] = '0; m_rresp[i] = '0; m_bresp[i] = '0;
      end
      tick();
      tick();
      chk("reset_idle_rr", 128'(act[0]), 128'(0));
      chk("reset_idle_fp", 128'(act[1]), 128'(0));
      rst = 1'b0;

      // single read on port 0, reply three cycles later
      u_rv[0] = 1'b1; u_raddr[0] = 32'h100; u_rrdy[0] = 1'b1; m_rqrdy[0] = 1'b1;
      #1;
      chk("rd0_grant_latency", 128'(mo_rv[0]), 128'(0));
      tick();
      chk("rd0_mem_valid", 128'(mo_rv[0]), 128'(1));
      chk("rd0_mem_addr", 128'(mo_raddr[0]), 128'(32'h100));
      chk("rd0_up0_ready", 128'(o_rqrdy[0]), 128'(1));
      chk("rd0_up1_ready", 128'(o_rqrdy[1]), 128'(0));
      tick();
      u_rv[0] = 1'b0; m_rqrdy[0] = 1'b0;
      #1;
      chk("rd0_wait_reply", 128'(o_rpv[0]), 128'(0));
      chk("rd0_mem_reply_ready", 128'(mo_rrdy[0]), 128'(1));
      tick();
      tick();
      m_rpv[0] = 1'b1; m_rdata[0] = {16{8'hA5}}; m_rresp[0] = 2'b00;
      #1;
      chk("rd0_reply_valid", 128'(o_rpv[0]), 128'(1));
      chk("rd0_reply_data", o_rdata[0], {16{8'hA5}});
      chk("rd0_reply_resp", 128'(o_rresp[0]), 128'(0));
      chk("rd0_up1_quiet", 128'({o_rpv[1], o_rqrdy[1]}), 128'(0));
      tick();
      m_rpv[0] = 1'b0;
      #1;
      chk("rd0_back_idle", 128'(act[0]), 128'(0));

      // port 1 read, reset while its reply is being presented
      u_rv[1] = 1'b1; u_raddr[1] = 32'h500; u_rrdy[1] = 1'b1; m_rqrdy[0] = 1'b1;
      tick();
      tick();
      u_rv[1] = 1'b0; m_rqrdy[0] = 1'b0; m_rpv[0] = 1'b1;
      #1;
      chk("rd1_reply_before_rst", 128'(o_rpv[1]), 128'(1));
      rst = 1'b1;
      #1;
      chk("rst_mid_rresp_rr", 128'(act[0]), 128'(0));
      chk("rst_mid_rresp_fp", 128'(act[1]), 128'(0));
      tick();
      m_rpv[0] = 1'b0;
      rst = 1'b0;

      // round-robin: both always requesting, first tie after reset to port 0
      u_rv = 2'b11; u_rrdy = 2'b11; u_raddr[0] = 32'h1000; u_raddr[1] = 32'h2000;
      mem_read(0, 0, 32'h1000);
      mem_read(0, 1, 32'h2000);
      mem_read(0, 0, 32'h1000);
      mem_read(0, 1, 32'h2000);

      // fixed priority: port 0 every time, port 1 only once port 0 goes quiet
      pulse_reset();
      mem_read(1, 0, 32'h1000);
      mem_read(1, 0, 32'h1000);
      mem_read(1, 0, 32'h1000);
      mem_read(1, 0, 32'h1000);
      u_rv[0] = 1'b0;
      mem_read(1, 1, 32'h2000);

      // port 1 write and read together: write goes first
      u_rv = '0;
      pulse_reset();
      u_wv[1] = 1'b1; u_waddr[1] = 32'h200; u_wmask[1] = 16'hFFFF;
      u_wdata[1] = {4{32'hDEADBEEF}}; u_rv[1] = 1'b1; u_raddr[1] = 32'h300;
      u_brdy[1] = 1'b1; u_rrdy[1] = 1'b1; m_wqrdy[0] = 1'b1; m_rqrdy[0] = 1'b1;
      tick();
      #1;
      chk("wr_first_valid", 128'(mo_wv[0]), 128'(1));
      chk("wr_first_no_read", 128'(mo_rv[0]), 128'(0));
      chk("wr_addr", 128'(mo_waddr[0]), 128'(32'h200));
      chk("wr_mask", 128'(mo_wmask[0]), 128'(16'hFFFF));
      chk("wr_data", mo_wdata[0], {4{32'hDEADBEEF}});
      chk("wr_up1_ready", 128'({o_wqrdy[1], o_rqrdy[1]}), 128'(2'b10));
      tick();
      u_wv[1] = 1'b0; m_wqrdy[0] = 1'b0; m_bv[0] = 1'b1; m_bresp[0] = 2'b01;
      #1;
      chk("wr_bresp_valid", 128'({o_bv[1], o_bv[0]}), 128'(2'b10));
      chk("wr_bresp", 128'(o_bresp[1]), 128'(2'b01));
      chk("wr_mem_b_ready", 128'(mo_brdy[0]), 128'(1));
      chk("wr_read_waits", 128'(mo_rv[0]), 128'(0));
      tick();
      m_bv[0] = 1'b0;
      #1;
      chk("wr_then_idle", 128'(act[0]), 128'(0));
      tick();
      chk("rd_after_wr_valid", 128'(mo_rv[0]), 128'(1));
      chk("rd_after_wr_addr", 128'(mo_raddr[0]), 128'(32'h300));
      tick();
      u_rv[1] = 1'b0; m_rqrdy[0] = 1'b0; m_rpv[0] = 1'b1; m_rdata[0] = {4{32'h0000_0300}};
      #1;
      chk("rd_after_wr_reply", o_rdata[1], {4{32'h0000_0300}});
      tick();
      m_rpv[0] = 1'b0;

      // back-pressure: request stalled 10 cycles, then reply held unaccepted
      u_rv[0] = 1'b1; u_raddr[0] = 32'h400; u_rrdy[0] = 1'b0; m_rqrdy[0] = 1'b0;
      tick();
      m_bv[0] = 1'b1;
      held_addr = 32'h400;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("stall_req_valid", 128'(mo_rv[0]), 128'(1));
         chk("stall_req_addr", 128'(mo_raddr[0]), 128'(held_addr));
         chk("stall_up_ready", 128'(o_rqrdy[0]), 128'(0));
         chk("stray_b_not_taken", 128'(mo_brdy[0]), 128'(0));
         tick();
      end
      m_bv[0] = 1'b0; m_rqrdy[0] = 1'b1;
      #1;
      chk("stall_release_ready", 128'(o_rqrdy[0]), 128'(1));
      tick();
      u_rv[0] = 1'b0; m_rqrdy[0] = 1'b0; m_rpv[0] = 1'b1; m_rdata[0] = {16{8'h5A}};
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("hold_reply_valid", 128'(o_rpv[0]), 128'(1));
         chk("hold_reply_data", o_rdata[0], {16{8'h5A}});
         chk("hold_mem_ready", 128'(mo_rrdy[0]), 128'(0));
         tick();
      end
      u_rrdy[0] = 1'b1;
      #1;
      chk("hold_release_ready", 128'(mo_rrdy[0]), 128'(1));
      tick();
      m_rpv[0] = 1'b0;
      #1;
      chk("hold_done_idle", 128'(act[0]), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
